// File: rtl/dlpc_cfg_pkg.sv
// Shared definitions for the DLPC300 configuration-interface arbiter:
// state encoding, interface widths and default timing constants.
package dlpc_cfg_pkg;

   localparam int DLPC_ADDR_W           = 8;
   localparam int DLPC_DATA_W           = 32;
   localparam int DEF_WR_GAP_CYCLES     = 32768;
   localparam int DEF_RD_TIMEOUT_CYCLES = 65535;
   localparam int DEF_CNT_W             = 16;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ISSUE   = 3'd1,
      ST_WAIT_WR = 3'd2,
      ST_WAIT_RD = 3'd3,
      ST_GUARD   = 3'd4,
      ST_RESP    = 3'd5
   } state_t;

   // Index reached by stepping 'step' places past 'last' in a ring of 'n'.
   function automatic int rr_wrap(input int last, input int step, input int n);
      return (last + step) % n;
   endfunction

endpackage

// File: rtl/dlpc_cfg_arbiter_rr.sv
// Combinational round-robin pick: the first requester set after rr_last_i,
// wrapping around, wins. Produces a one-hot grant and its index.
module rr_arbiter
   import dlpc_cfg_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = 2
) (
   input  logic [NUM_REQ-1:0] req_valid_i,
   input  logic [IDX_W-1:0]   rr_last_i,
   output logic [NUM_REQ-1:0] grant_oh_o,
   output logic [IDX_W-1:0]   grant_idx_o,
   output logic               any_o
);

   logic [IDX_W-1:0] cand_s [NUM_REQ];

   // cand_s[k] is the requester k+1 places after the last winner
   for (genvar k = 0; k < NUM_REQ; k++) begin : g_cand
      assign cand_s[k] = IDX_W'(rr_wrap(int'(rr_last_i), k + 1, NUM_REQ));
   end

   // Scan from farthest to nearest so the nearest set candidate wins
   always_comb begin
      grant_oh_o  = '0;
      grant_idx_o = '0;
      any_o       = 1'b0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (req_valid_i[cand_s[k]]) begin
            grant_oh_o  = NUM_REQ'(1) << cand_s[k];
            grant_idx_o = cand_s[k];
            any_o       = 1'b1;
         end else begin
            grant_oh_o  = grant_oh_o;
         end
      end
   end

endmodule

// File: rtl/dlpc_cfg_arbiter.sv
// Round-robin arbiter and sequencer sharing the single DLPC300 I2C
// configuration interface. Downstream address/data are held stable for the
// whole transaction; writes complete after a fixed guard time and reads are
// bounded by a timeout followed by a drain period.
module dlpc_cfg_arbiter
   import dlpc_cfg_pkg::*;
#(
   parameter int NUM_REQ           = 4,
   parameter int WR_GAP_CYCLES     = DEF_WR_GAP_CYCLES,
   parameter int RD_TIMEOUT_CYCLES = DEF_RD_TIMEOUT_CYCLES,
   parameter int CNT_W             = DEF_CNT_W
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [NUM_REQ-1:0]               req_valid,
   input  logic [NUM_REQ-1:0]               req_write,
   input  logic [NUM_REQ*DLPC_ADDR_W-1:0]   req_addr,
   input  logic [NUM_REQ*DLPC_DATA_W-1:0]   req_wdata,
   output logic [NUM_REQ-1:0]               req_grant,
   output logic [NUM_REQ-1:0]               rsp_valid,
   output logic [DLPC_DATA_W-1:0]           rsp_rdata,
   output logic                             rsp_timeout,
   output logic                             busy,
   output logic [DLPC_ADDR_W-1:0]           dlpc_address,
   output logic                             dlpc_wr_req,
   output logic [DLPC_DATA_W-1:0]           dlpc_wr_data,
   output logic                             dlpc_wr_valid,
   input  logic                             dlpc_wr_ready,
   output logic                             dlpc_rd_req,
   input  logic [DLPC_DATA_W-1:0]           dlpc_rd_data,
   input  logic                             dlpc_rd_valid,
   output logic                             dlpc_rd_ready
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(WR_GAP_CYCLES - 1);
   localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(RD_TIMEOUT_CYCLES - 1);

   state_t                 state_q;
   logic [IDX_W-1:0]       rr_last_q;
   logic [CNT_W-1:0]       cnt_q;
   logic [NUM_REQ-1:0]     owner_q;
   logic                   write_q;
   logic [NUM_REQ-1:0]     grant_q;
   logic [NUM_REQ-1:0]     rsp_valid_q;
   logic [DLPC_DATA_W-1:0] rsp_rdata_q;
   logic                   rsp_timeout_q;
   logic [DLPC_ADDR_W-1:0] addr_q;
   logic [DLPC_DATA_W-1:0] wdata_q;
   logic                   wr_req_q;
   logic                   rd_req_q;

   logic [NUM_REQ-1:0]     grant_oh_s;
   logic [IDX_W-1:0]       grant_idx_s;
   logic                   any_s;
   logic [DLPC_ADDR_W-1:0] addr_arr_s  [NUM_REQ];
   logic [DLPC_DATA_W-1:0] wdata_arr_s [NUM_REQ];
   logic                   unused_wr_ready_s;

   // The interface ties its write-ready high; it carries no information here
   assign unused_wr_ready_s = dlpc_wr_ready;

   // Unpack the per-requester address and data slices
   for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
      assign addr_arr_s[i]  = req_addr[DLPC_ADDR_W*i +: DLPC_ADDR_W];
      assign wdata_arr_s[i] = req_wdata[DLPC_DATA_W*i +: DLPC_DATA_W];
   end

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_rr (
      .req_valid_i (req_valid),
      .rr_last_i   (rr_last_q),
      .grant_oh_o  (grant_oh_s),
      .grant_idx_o (grant_idx_s),
      .any_o       (any_s)
   );

   // Transaction sequencer: grant, issue, wait/timeout/drain, respond
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         rr_last_q     <= IDX_W'(NUM_REQ - 1);
         cnt_q         <= '0;
         owner_q       <= '0;
         write_q       <= 1'b0;
         grant_q       <= '0;
         rsp_valid_q   <= '0;
         rsp_rdata_q   <= '0;
         rsp_timeout_q <= 1'b0;
         addr_q        <= '0;
         wdata_q       <= '0;
         wr_req_q      <= 1'b0;
         rd_req_q      <= 1'b0;
      end else begin
         grant_q     <= '0;
         rsp_valid_q <= '0;
         wr_req_q    <= 1'b0;
         rd_req_q    <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (any_s) begin
                  state_q   <= ST_ISSUE;
                  owner_q   <= grant_oh_s;
                  rr_last_q <= grant_idx_s;
                  write_q   <= req_write[grant_idx_s];
                  addr_q    <= addr_arr_s[grant_idx_s];
                  wdata_q   <= wdata_arr_s[grant_idx_s];
                  grant_q   <= grant_oh_s;
               end else begin
                  state_q   <= ST_IDLE;
               end
            end
            ST_ISSUE: begin
               cnt_q <= '0;
               if (write_q) begin
                  wr_req_q <= 1'b1;
                  state_q  <= ST_WAIT_WR;
               end else begin
                  rd_req_q <= 1'b1;
                  state_q  <= ST_WAIT_RD;
               end
            end
            ST_WAIT_WR: begin
               if (cnt_q == WR_LAST) begin
                  state_q       <= ST_RESP;
                  rsp_valid_q   <= owner_q;
                  rsp_rdata_q   <= '0;
                  rsp_timeout_q <= 1'b0;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            ST_WAIT_RD: begin
               // Returned data takes priority over a simultaneous terminal count
               if (dlpc_rd_valid) begin
                  state_q       <= ST_RESP;
                  rsp_valid_q   <= owner_q;
                  rsp_rdata_q   <= dlpc_rd_data;
                  rsp_timeout_q <= 1'b0;
               end else if (cnt_q == RD_LAST) begin
                  state_q       <= ST_GUARD;
                  cnt_q         <= '0;
                  rsp_rdata_q   <= '0;
                  rsp_timeout_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            ST_GUARD: begin
               // Let the stalled I2C transfer drain before releasing the bus
               if (cnt_q == WR_LAST) begin
                  state_q     <= ST_RESP;
                  rsp_valid_q <= owner_q;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            ST_RESP: begin
               state_q       <= ST_IDLE;
               rsp_rdata_q   <= '0;
               rsp_timeout_q <= 1'b0;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign req_grant     = grant_q;
   assign rsp_valid     = rsp_valid_q;
   assign rsp_rdata     = rsp_rdata_q;
   assign rsp_timeout   = rsp_timeout_q;
   assign busy          = (state_q != ST_IDLE);
   assign dlpc_address  = addr_q;
   assign dlpc_wr_data  = wdata_q;
   assign dlpc_wr_req   = wr_req_q;
   assign dlpc_wr_valid = wr_req_q;
   assign dlpc_rd_req   = rd_req_q;
   assign dlpc_rd_ready = 1'b1;

endmodule

// File: tb/tb_dlpc_cfg_arbiter.sv
// Self-checking bench for dlpc_cfg_arbiter with a behavioural reference model.
module tb_dlpc_cfg_arbiter;

   localparam int NR     = 4;
   localparam int WR_GAP = 16;
   localparam int RD_TO  = 600;
   localparam int LIMIT  = 2000;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [NR-1:0]   req_valid = '0;
   logic [NR-1:0]   req_write = '0;
   logic [NR*8-1:0] req_addr  = '0;
   logic [NR*32-1:0] req_wdata = '0;
   logic [NR-1:0]   req_grant;
   logic [NR-1:0]   rsp_valid;
   logic [31:0]     rsp_rdata;
   logic            rsp_timeout;
   logic            busy;
   logic [7:0]      dlpc_address;
   logic            dlpc_wr_req;
   logic [31:0]     dlpc_wr_data;
   logic            dlpc_wr_valid;
   logic            dlpc_wr_ready = 1'b1;
   logic            dlpc_rd_req;
   logic [31:0]     dlpc_rd_data = '0;
   logic            dlpc_rd_valid = 1'b0;
   logic            dlpc_rd_ready;

   always #5 clk = ~clk;

   dlpc_cfg_arbiter #(
      .NUM_REQ           (NR),
      .WR_GAP_CYCLES     (WR_GAP),
      .RD_TIMEOUT_CYCLES (RD_TO),
      .CNT_W             (16)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .req_valid     (req_valid),
      .req_write     (req_write),
      .req_addr      (req_addr),
      .req_wdata     (req_wdata),
      .req_grant     (req_grant),
      .rsp_valid     (rsp_valid),
      .rsp_rdata     (rsp_rdata),
      .rsp_timeout   (rsp_timeout),
      .busy          (busy),
      .dlpc_address  (dlpc_address),
      .dlpc_wr_req   (dlpc_wr_req),
      .dlpc_wr_data  (dlpc_wr_data),
      .dlpc_wr_valid (dlpc_wr_valid),
      .dlpc_wr_ready (dlpc_wr_ready),
      .dlpc_rd_req   (dlpc_rd_req),
      .dlpc_rd_data  (dlpc_rd_data),
      .dlpc_rd_valid (dlpc_rd_valid),
      .dlpc_rd_ready (dlpc_rd_ready)
   );

   int n_cmp = 0;
   int n_err = 0;

   // requester-side transaction descriptors
   logic        t_write [NR];
   logic [7:0]  t_addr  [NR];
   logic [31:0] t_wdata [NR];
   logic [31:0] t_rd_data;

   // reference model state: last winner
   int m_last;

   // observations from the last transaction
   logic [NR-1:0] obs_gnt_oh, obs_rsp_oh, obs_after_rsp;
   int            obs_gnt_lat, obs_rsp_lat, obs_pulse_off;
   int            obs_wr_pulses, obs_rd_pulses, obs_addr_changes;
   int            obs_extra_gnt, obs_busy_gap, obs_wrvalid_mis;
   logic [31:0]   obs_rdata, obs_data;
   logic [7:0]    obs_addr;
   logic          obs_to, obs_busy_after;

   // model: first pending requester after the last winner, wrapping
   function automatic int m_pick(input logic [NR-1:0] mask);
      for (int k = 1; k <= NR; k++) begin
         if (mask[(m_last + k) % NR]) return (m_last + k) % NR;
      end
      return -1;
   endfunction

   // model: grant-to-response cycles for a transaction
   function automatic int m_rsp_lat(input logic wr, input int rd_lat);
      if (wr) return WR_GAP + 1;
      if (rd_lat >= 0 && rd_lat < RD_TO) return rd_lat + 2;
      return RD_TO + WR_GAP + 1;
   endfunction

   task automatic drive_inputs(input logic [NR-1:0] mask);
      for (int i = 0; i < NR; i++) begin
         req_write[i]          = t_write[i];
         req_addr[8*i +: 8]    = t_addr[i];
         req_wdata[32*i +: 32] = t_wdata[i];
      end
      req_valid = mask;
   endtask

   // Run one transaction and record what the DUT did (no checking here)
   task automatic run_one(input logic [NR-1:0] mask, input logic [NR-1:0] drop_mask,
                          input int rd_lat, input int stray_at);
      int g, p;
      bit done;
      logic [NR-1:0] vmask;
      vmask = mask;
      drive_inputs(vmask);
      obs_gnt_oh = '0; obs_rsp_oh = '0; obs_after_rsp = '1;
      obs_gnt_lat = -1; obs_rsp_lat = -1; obs_pulse_off = -1;
      obs_wr_pulses = 0; obs_rd_pulses = 0; obs_addr_changes = 0;
      obs_extra_gnt = 0; obs_busy_gap = 0; obs_wrvalid_mis = 0;
      obs_rdata = '0; obs_data = '0; obs_addr = '0; obs_to = 1'b0; obs_busy_after = 1'b1;
      g = -1; p = -1; done = 1'b0;
      for (int c = 1; c <= LIMIT && !done; c++) begin
         @(posedge clk); #1;
         dlpc_rd_valid = 1'b0;
         if (req_grant != '0) begin
            if (g < 0) begin
               g = c; obs_gnt_oh = req_grant; obs_gnt_lat = c;
               vmask = vmask & ~req_grant; req_valid = vmask;
            end else begin
               obs_extra_gnt++;
            end
         end
         if (g >= 0 && c == g + 2) begin vmask = vmask & ~drop_mask; req_valid = vmask; end
         if (dlpc_wr_valid !== dlpc_wr_req) obs_wrvalid_mis++;
         if (dlpc_wr_req) begin obs_wr_pulses++; if (obs_pulse_off < 0) obs_pulse_off = c - g; end
         if (dlpc_rd_req) begin
            obs_rd_pulses++;
            if (p < 0) p = c;
            if (obs_pulse_off < 0) obs_pulse_off = c - g;
         end
         if (g >= 0 && c == g + 1) begin
            obs_addr = dlpc_address; obs_data = dlpc_wr_data;
         end else if (g >= 0 && c > g + 1 && rsp_valid == '0 &&
                      (dlpc_address !== obs_addr || dlpc_wr_data !== obs_data)) begin
            obs_addr_changes++;
         end
         if (g >= 0 && rsp_valid == '0 && busy !== 1'b1) obs_busy_gap++;
         if (p >= 0 && rd_lat >= 0 && c == p + rd_lat) begin
            dlpc_rd_valid = 1'b1; dlpc_rd_data = t_rd_data;
         end
         if (g >= 0 && stray_at >= 0 && c == g + stray_at) begin
            dlpc_rd_valid = 1'b1; dlpc_rd_data = $urandom;
         end
         if (rsp_valid != '0) begin
            obs_rsp_lat = (g >= 0) ? c - g : c;
            obs_rsp_oh = rsp_valid; obs_rdata = rsp_rdata; obs_to = rsp_timeout;
            done = 1'b1;
         end
      end
      dlpc_rd_valid = 1'b0;
      if (done) begin
         @(posedge clk); #1;
         obs_after_rsp = rsp_valid; obs_busy_after = busy;
      end
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1;
      n_cmp++;
      if ({req_grant, rsp_valid, rsp_rdata, rsp_timeout, busy, dlpc_address,
           dlpc_wr_req, dlpc_wr_data, dlpc_wr_valid, dlpc_rd_req} !== '0) begin
         n_err++; $display("FAIL reset_outputs: actual nonzero output(s) grant=%b rsp=%b busy=%b addr=%h",
                           req_grant, rsp_valid, busy, dlpc_address);
      end
      n_cmp++;
      if (dlpc_rd_ready !== 1'b1) begin n_err++; $display("FAIL reset_rd_ready: actual %b expected 1", dlpc_rd_ready); end
      rst = 1'b0;
      m_last = NR - 1;
   endtask

   task automatic test_single_write();
      t_write[0] = 1'b1; t_addr[0] = 8'h15; t_wdata[0] = 32'hDEADBEEF;
      run_one(4'b0001, 4'b0000, -1, -1);
      m_last = 0;
      n_cmp++; if (obs_gnt_oh !== 4'b0001) begin n_err++; $display("FAIL sw_grant: actual %b expected 0001", obs_gnt_oh); end
      n_cmp++; if (obs_gnt_lat !== 1) begin n_err++; $display("FAIL sw_grant_lat: actual %0d expected 1", obs_gnt_lat); end
      n_cmp++; if (obs_wr_pulses !== 1 || obs_rd_pulses !== 0) begin n_err++; $display("FAIL sw_pulses: actual wr=%0d rd=%0d expected wr=1 rd=0", obs_wr_pulses, obs_rd_pulses); end
      n_cmp++; if (obs_wrvalid_mis !== 0) begin n_err++; $display("FAIL sw_wr_valid_mirror: actual %0d mismatched cycles expected 0", obs_wrvalid_mis); end
      n_cmp++; if (obs_addr !== 8'h15 || obs_data !== 32'hDEADBEEF) begin n_err++; $display("FAIL sw_addr_data: actual %h/%h expected 15/deadbeef", obs_addr, obs_data); end
      n_cmp++; if (obs_addr_changes !== 0) begin n_err++; $display("FAIL sw_hold: actual %0d changes expected 0", obs_addr_changes); end
      n_cmp++; if (obs_rsp_oh !== 4'b0001 || obs_to !== 1'b0 || obs_rdata !== 32'h0) begin n_err++; $display("FAIL sw_rsp: actual %b to=%b data=%h expected 0001 to=0 data=0", obs_rsp_oh, obs_to, obs_rdata); end
      n_cmp++; if (obs_rsp_lat !== WR_GAP + 1) begin n_err++; $display("FAIL sw_rsp_lat: actual %0d expected %0d", obs_rsp_lat, WR_GAP + 1); end
      n_cmp++; if (obs_after_rsp !== 4'b0000 || obs_busy_after !== 1'b0 || obs_busy_gap !== 0) begin n_err++; $display("FAIL sw_end: actual rsp=%b busy=%b gaps=%0d expected 0000 0 0", obs_after_rsp, obs_busy_after, obs_busy_gap); end
   endtask

   task automatic test_read();
      t_write[2] = 1'b0; t_addr[2] = 8'h0C; t_wdata[2] = 32'h0; t_rd_data = 32'h12345678;
      run_one(4'b0100, 4'b0000, 500, -1);
      m_last = 2;
      n_cmp++; if (obs_gnt_oh !== 4'b0100 || obs_rsp_oh !== 4'b0100) begin n_err++; $display("FAIL rd_owner: actual gnt=%b rsp=%b expected 0100", obs_gnt_oh, obs_rsp_oh); end
      n_cmp++; if (obs_rd_pulses !== 1 || obs_wr_pulses !== 0 || obs_pulse_off !== 1) begin n_err++; $display("FAIL rd_pulse: actual rd=%0d wr=%0d off=%0d expected 1 0 1", obs_rd_pulses, obs_wr_pulses, obs_pulse_off); end
      n_cmp++; if (obs_addr !== 8'h0C) begin n_err++; $display("FAIL rd_addr: actual %h expected 0c", obs_addr); end
      n_cmp++; if (obs_rdata !== 32'h12345678 || obs_to !== 1'b0) begin n_err++; $display("FAIL rd_data: actual %h to=%b expected 12345678 to=0", obs_rdata, obs_to); end
      n_cmp++; if (obs_rsp_lat !== m_rsp_lat(1'b0, 500)) begin n_err++; $display("FAIL rd_lat: actual %0d expected %0d", obs_rsp_lat, m_rsp_lat(1'b0, 500)); end
   endtask

   task automatic test_round_robin();
      int exp_w;
      for (int i = 0; i < NR; i++) begin t_write[i] = 1'b1; t_addr[i] = 8'($urandom); t_wdata[i] = $urandom; end
      for (int n = 0; n < 8; n++) begin
         exp_w = m_pick(4'b1111);
         run_one(4'b1111, 4'b0000, -1, -1);
         m_last = exp_w;
         n_cmp++; if (obs_gnt_oh !== (4'b0001 << exp_w) || obs_extra_gnt !== 0) begin n_err++; $display("FAIL rr_order%0d: actual gnt=%b extra=%0d expected %0d extra=0", n, obs_gnt_oh, obs_extra_gnt, exp_w); end
         n_cmp++; if (obs_addr !== t_addr[exp_w] || obs_rsp_oh !== obs_gnt_oh) begin n_err++; $display("FAIL rr_txn%0d: actual addr=%h rsp=%b expected addr=%h rsp=%b", n, obs_addr, obs_rsp_oh, t_addr[exp_w], obs_gnt_oh); end
      end
   endtask

   task automatic test_stray();
      t_write[1] = 1'b1; t_addr[1] = 8'h33; t_wdata[1] = 32'hA5A5_0F0F;
      run_one(4'b0010, 4'b0000, -1, 5);
      m_last = 1;
      n_cmp++; if (obs_rsp_lat !== WR_GAP + 1 || obs_rdata !== 32'h0 || obs_to !== 1'b0) begin n_err++; $display("FAIL stray_wr: actual lat=%0d data=%h to=%b expected %0d 0 0", obs_rsp_lat, obs_rdata, obs_to, WR_GAP + 1); end
      n_cmp++; if (obs_rsp_oh !== 4'b0010 || obs_addr_changes !== 0) begin n_err++; $display("FAIL stray_rsp: actual rsp=%b changes=%0d expected 0010 0", obs_rsp_oh, obs_addr_changes); end
   endtask

   task automatic test_drop();
      int exp_w, late;
      for (int i = 0; i < NR; i++) begin t_write[i] = 1'b1; t_addr[i] = 8'(8'h40 + i); t_wdata[i] = $urandom; end
      exp_w = m_pick(4'b1001);
      run_one(4'b1001, 4'b1001, -1, -1);
      m_last = exp_w;
      n_cmp++; if (obs_gnt_oh !== (4'b0001 << exp_w)) begin n_err++; $display("FAIL drop_first: actual %b expected idx %0d", obs_gnt_oh, exp_w); end
      late = 0;
      for (int c = 0; c < 8; c++) begin @(posedge clk); #1; if (req_grant != '0 || rsp_valid != '0) late++; end
      n_cmp++; if (late !== 0) begin n_err++; $display("FAIL drop_no_grant: actual %0d stray cycles expected 0", late); end
   endtask

   task automatic test_timeout();
      int lats [3];
      lats[0] = -1; lats[1] = RD_TO; lats[2] = RD_TO - 1;
      t_write[1] = 1'b0; t_addr[1] = 8'h7E;
      for (int n = 0; n < 3; n++) begin
         t_rd_data = $urandom;
         run_one(4'b0010, 4'b0000, lats[n], -1);
         m_last = 1;
         n_cmp++; if (obs_rsp_lat !== m_rsp_lat(1'b0, lats[n])) begin n_err++; $display("FAIL to_lat%0d: actual %0d expected %0d", n, obs_rsp_lat, m_rsp_lat(1'b0, lats[n])); end
         if (n < 2) begin
            n_cmp++; if (obs_to !== 1'b1 || obs_rdata !== 32'h0 || obs_rsp_oh !== 4'b0010) begin n_err++; $display("FAIL to_flag%0d: actual to=%b data=%h rsp=%b expected 1 0 0010", n, obs_to, obs_rdata, obs_rsp_oh); end
         end else begin
            n_cmp++; if (obs_to !== 1'b0 || obs_rdata !== t_rd_data) begin n_err++; $display("FAIL to_terminal: actual to=%b data=%h expected 0 %h", obs_to, obs_rdata, t_rd_data); end
         end
      end
   endtask

   task automatic test_random();
      int exp_w, rd_lat, exp_lat;
      logic [NR-1:0] mask;
      logic [31:0] exp_data;
      logic exp_to;
      for (int n = 0; n < 12; n++) begin
         mask = NR'($urandom_range(1, (1 << NR) - 1));
         for (int i = 0; i < NR; i++) begin
            t_write[i] = 1'($urandom); t_addr[i] = 8'($urandom); t_wdata[i] = $urandom;
         end
         t_rd_data = $urandom;
         rd_lat = ($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(0, 60));
         exp_w = m_pick(mask);
         exp_lat = m_rsp_lat(t_write[exp_w], rd_lat);
         exp_to = !t_write[exp_w] && rd_lat < 0;
         exp_data = (t_write[exp_w] || exp_to) ? 32'h0 : t_rd_data;
         run_one(mask, 4'b0000, rd_lat, -1);
         m_last = exp_w;
         n_cmp++;
         if (obs_gnt_oh !== (4'b0001 << exp_w) || obs_rsp_oh !== (4'b0001 << exp_w) || obs_extra_gnt !== 0) begin
            n_err++; $display("FAIL rnd_owner%0d: actual gnt=%b rsp=%b extra=%0d expected idx %0d", n, obs_gnt_oh, obs_rsp_oh, obs_extra_gnt, exp_w);
         end
         n_cmp++;
         if (obs_rsp_lat !== exp_lat || obs_to !== exp_to || obs_rdata !== exp_data) begin
            n_err++; $display("FAIL rnd_rsp%0d: actual lat=%0d to=%b data=%h expected %0d %b %h", n, obs_rsp_lat, obs_to, obs_rdata, exp_lat, exp_to, exp_data);
         end
         n_cmp++;
         if (obs_addr !== t_addr[exp_w] || obs_data !== t_wdata[exp_w] || obs_addr_changes !== 0) begin
            n_err++; $display("FAIL rnd_dp%0d: actual %h/%h chg=%0d expected %h/%h", n, obs_addr, obs_data, obs_addr_changes, t_addr[exp_w], t_wdata[exp_w]);
         end
      end
   endtask

   task automatic test_reset_mid();
      bit seen;
      t_write[2] = 1'b0; t_addr[2] = 8'h0C;
      drive_inputs(4'b0100);
      seen = 1'b0;
      for (int c = 0; c < 20 && !seen; c++) begin
         @(posedge clk); #1;
         if (dlpc_rd_req) seen = 1'b1;
         if (req_grant != '0) req_valid = '0;
      end
      n_cmp++; if (seen !== 1'b1) begin n_err++; $display("FAIL rm_issue: actual rd_req seen=%b expected 1", seen); end
      repeat (20) @(posedge clk);
      #1;
      n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL rm_busy_pre: actual %b expected 1", busy); end
      rst = 1'b1;
      #1;
      n_cmp++;
      if ({req_grant, rsp_valid, rsp_rdata, rsp_timeout, busy, dlpc_address,
           dlpc_wr_req, dlpc_wr_data, dlpc_wr_valid, dlpc_rd_req} !== '0 || dlpc_rd_ready !== 1'b1) begin
         n_err++; $display("FAIL rm_async_reset: actual busy=%b addr=%h rsp=%b rdy=%b expected all 0 rdy=1", busy, dlpc_address, rsp_valid, dlpc_rd_ready);
      end
      t_write[0] = 1'b1; t_addr[0] = 8'h21; t_wdata[0] = 32'h0000_0021;
      t_write[3] = 1'b1; t_addr[3] = 8'h23; t_wdata[3] = 32'h0000_0023;
      drive_inputs(4'b1001);
      repeat (2) @(posedge clk);
      #1;
      n_cmp++; if (rsp_valid !== 4'b0000 || req_grant !== 4'b0000) begin n_err++; $display("FAIL rm_hold: actual rsp=%b gnt=%b expected 0", rsp_valid, req_grant); end
      rst = 1'b0;
      m_last = NR - 1;
      run_one(4'b1001, 4'b0000, -1, -1);
      n_cmp++; if (obs_gnt_oh !== (4'b0001 << m_pick(4'b1001)) || obs_gnt_lat !== 1) begin n_err++; $display("FAIL rm_first: actual %b lat=%0d expected idx %0d lat 1", obs_gnt_oh, obs_gnt_lat, m_pick(4'b1001)); end
      m_last = m_pick(4'b1001);
      run_one(4'b1000, 4'b0000, -1, -1);
      n_cmp++; if (obs_gnt_oh !== 4'b1000 || obs_rsp_oh !== 4'b1000) begin n_err++; $display("FAIL rm_second: actual gnt=%b rsp=%b expected 1000", obs_gnt_oh, obs_rsp_oh); end
      m_last = 3;
   endtask

   initial begin
      for (int i = 0; i < NR; i++) begin t_write[i] = 1'b0; t_addr[i] = '0; t_wdata[i] = '0; end
      t_rd_data = '0;
      m_last = NR - 1;
      test_reset();
      test_single_write();
      test_read();
      test_round_robin();
      test_stray();
      test_drop();
      test_timeout();
      test_random();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: actual simulation still running expected finished");
      $fatal(1);
   end

endmodule

// File: doc/dlpc_cfg_arbiter.md
Name: dlpc_cfg_arbiter

Overview:
- Round-robin arbiter and sequencer sharing the single DLPC300 I2C configuration interface among NUM_REQ requesters (boot sequencer, video timing control, host register bridge, debug).
- Sits between the requesters and the dlpc300 config interface (address / wr_req / wr_data / rd_req / rd_data).
- That interface gives no write-completion indication and samples address and data across the whole I2C transaction. This block therefore holds the downstream signals stable, times write completion with a guard counter, and bounds reads with a timeout.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- WR_GAP_CYCLES, 32768, clk cycles after a write request before the interface is considered free (covers 6 I2C bytes at 100 kHz with 50 MHz clk, plus margin)
- RD_TIMEOUT_CYCLES, 65535, maximum wait for dlpc_rd_valid
- CNT_W, 16, width of the gap/timeout counter; must hold both cycle counts

Ports:
- clk, in, 1, system clock
- rst, in, 1, asynchronous active-high reset
- req_valid, in, NUM_REQ, per-requester request; held until req_grant
- req_write, in, NUM_REQ, 1 = write, 0 = read
- req_addr, in, NUM_REQ*8, packed register addresses; slice i = [8i+7:8i]
- req_wdata, in, NUM_REQ*32, packed write data
- req_grant, out, NUM_REQ, one-hot, 1-cycle pulse when a request is accepted
- rsp_valid, out, NUM_REQ, one-hot, 1-cycle completion pulse to the owner
- rsp_rdata, out, 32, read data, shared; valid with rsp_valid
- rsp_timeout, out, 1, qualifies rsp_valid: the read timed out
- busy, out, 1, high in any state other than IDLE
- dlpc_address, out, 8, register address to the config interface
- dlpc_wr_req, out, 1, write request pulse
- dlpc_wr_data, out, 32, write data
- dlpc_wr_valid, out, 1, mirrors dlpc_wr_req
- dlpc_wr_ready, in, 1, ignored; the interface ties it high
- dlpc_rd_req, out, 1, read request pulse
- dlpc_rd_data, in, 32, read result
- dlpc_rd_valid, in, 1, read result valid
- dlpc_rd_ready, out, 1, tied high

Behaviour:
- Reset values:
  - all outputs 0, except dlpc_rd_ready = 1
  - state IDLE; rr_last = NUM_REQ-1, so requester 0 wins first
  - counter 0
- States: IDLE, ISSUE, WAIT_WR, WAIT_RD, GUARD, RESP.
- IDLE:
  - If any req_valid is set, pick the winner: first set index after rr_last, wrapping modulo NUM_REQ.
  - Same cycle, register owner, write flag, address and data; pulse req_grant[owner]; update rr_last; go to ISSUE.
  - Grant latency from req_valid is 1 clk.
- ISSUE (1 cycle):
  - Pulse dlpc_wr_req and dlpc_wr_valid for a write, or dlpc_rd_req for a read.
  - Load the counter with 0; go to WAIT_WR or WAIT_RD.
- dlpc_address and dlpc_wr_data hold the latched values from ISSUE until return to IDLE; they never change mid-transaction.
- WAIT_WR: counter increments; at WR_GAP_CYCLES-1 go to RESP with rsp_timeout = 0, rsp_rdata = 0.
- WAIT_RD:
  - On dlpc_rd_valid: capture dlpc_rd_data, go to RESP with rsp_timeout = 0.
  - Otherwise, at count RD_TIMEOUT_CYCLES-1 go to GUARD, with rsp_rdata = 0 and rsp_timeout latched to 1.
- GUARD: counter restarts from 0 and runs WR_GAP_CYCLES cycles to let the stalled I2C transaction drain, then go to RESP.
- RESP (1 cycle):
  - Pulse rsp_valid[owner]; rsp_rdata and rsp_timeout are valid this cycle.
  - Next state IDLE; a new grant can occur the cycle after RESP. Minimum request spacing is therefore ISSUE + wait + RESP + IDLE.
- A dlpc_rd_valid arriving while in WAIT_WR, GUARD or IDLE is ignored (stale).
- A dlpc_rd_valid in the same cycle as the timeout terminal count: data wins, no timeout.
- req_valid deasserted before grant: request is dropped, no response.
- Requester inputs are sampled only at grant.
- Fairness: a continuously requesting requester cannot win twice while another requester is waiting.
- Reset mid-transaction: everything returns to reset values immediately (asynchronous). No response is issued for the aborted request.

Decomposition:
- Package dlpc_cfg_pkg holds:
  - state encoding (3-bit localparams IDLE..RESP)
  - DLPC address width 8 and data width 32
  - default gap and timeout constants
- Sub-module rr_arbiter holds the combinational round-robin pick from req_valid and rr_last, producing a one-hot grant plus index. The FSM, counter and datapath latch stay in the top level.

Test Plan:
- Single write: req0 write, addr 0x15, data 0xDEADBEEF
  - req_grant[0] 1 clk after req_valid
  - dlpc_wr_req 1-cycle pulse with dlpc_address 0x15 and data 0xDEADBEEF
  - address and data stable for WR_GAP_CYCLES
  - rsp_valid[0] with rsp_timeout = 0
- Read: req2 read, addr 0x0C; model returns dlpc_rd_valid 500 clk after rd_req with 0x12345678 → rsp_valid[2], rsp_rdata = 0x12345678, rsp_timeout = 0.
- Round-robin: all 4 request continuously for 8 transactions (WR_GAP_CYCLES = 16) → grant order 0,1,2,3,0,1,2,3; never two grants in flight.
- Read timeout: no dlpc_rd_valid; RD_TIMEOUT_CYCLES = 100, WR_GAP_CYCLES = 16 → rsp_valid[owner] with rsp_timeout = 1 exactly 100 + 16 cycles after WAIT_RD entry (plus RESP), rsp_rdata = 0.
- Boundary: rd_valid on the terminal-count cycle → data returned, rsp_timeout = 0. A stray rd_valid during WAIT_WR → no rsp and no state change.
- Reset mid-read: assert rst during WAIT_RD → all outputs 0 at once, busy = 0. After release, req3 and req0 pending → req0 granted first.
